// File: rtl/nrd_mantissa_multiplier_pkg.sv
// Shared FPU significand constants, FSM state encoding and the multiply result
// record handed to the rounding stage.
package nrd_mantissa_multiplier_pkg;

    localparam int MANT_LENGTH = 24;
    localparam int PROD_LENGTH = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    typedef struct packed {
        logic [PROD_LENGTH-1:0] product;
        logic                   norm;
        logic [MANT_LENGTH-1:0] mantissa;
        logic                   sticky;
    } mul_result_t;

endpackage

// File: rtl/mul_norm_sticky.sv
// Maps a double-width significand product onto the normalisation flag, the
// retained significand and the sticky bit feeding the rounder.
module mul_norm_sticky #(
    parameter int  MANT_W = 24,
    localparam int PROD_W = 2 * MANT_W
) (
    input  logic [PROD_W-1:0] product,
    output logic              norm,
    output logic [MANT_W-1:0] mantissa,
    output logic              sticky
);

    // A set top bit means the product lies in [2,4) and the window slides up one bit.
    always_comb begin
        norm     = product[PROD_W-1];
        mantissa = {MANT_W{1'b0}};
        sticky   = 1'b0;
        if (norm) begin
            mantissa = product[PROD_W-1 -: MANT_W];
            sticky   = |product[PROD_W-MANT_W-1:0];
        end else begin
            mantissa = product[PROD_W-2 -: MANT_W];
            sticky   = |product[PROD_W-MANT_W-2:0];
        end
    end

endmodule

// File: rtl/nrd_mantissa_multiplier.sv
// Sequential radix-2 shift-add significand multiplier: one operation at a time,
// fixed MULTIPLIER_LENGTH-cycle latency, result held until consumed.
module nrd_mantissa_multiplier
    import nrd_mantissa_multiplier_pkg::*;
#(
    parameter int  MULTIPLICAND_LENGTH = MANT_LENGTH,
    parameter int  MULTIPLIER_LENGTH   = MANT_LENGTH,
    localparam int PRODUCT_LENGTH      = MULTIPLICAND_LENGTH + MULTIPLIER_LENGTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MULTIPLICAND_LENGTH-1:0] a,
    input  logic [MULTIPLIER_LENGTH-1:0]   b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PRODUCT_LENGTH-1:0]      product,
    output logic                           norm,
    output logic [MULTIPLICAND_LENGTH-1:0] mantissa,
    output logic                           sticky
);

    localparam int               CNT_W    = $clog2(MULTIPLIER_LENGTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULTIPLIER_LENGTH - 1);

    mul_state_t state_r;
    mul_state_t state_next_s;

    // acc carries one extra bit so the carry out of each partial sum survives the shift.
    logic [MULTIPLICAND_LENGTH:0]   acc_r;
    logic [MULTIPLICAND_LENGTH-1:0] mcand_r;
    logic [MULTIPLIER_LENGTH-1:0]   mq_r;
    logic [CNT_W-1:0]               cnt_r;

    logic [MULTIPLICAND_LENGTH:0]   addend_s;
    logic [MULTIPLICAND_LENGTH:0]   sum_s;
    logic [MULTIPLICAND_LENGTH:0]   acc_next_s;
    logic [MULTIPLIER_LENGTH-1:0]   mq_next_s;
    logic [PRODUCT_LENGTH-1:0]      product_next_s;
    logic                           norm_next_s;
    logic [MULTIPLICAND_LENGTH-1:0] mant_next_s;
    logic                           sticky_next_s;
    logic                           last_iter_s;

    mul_result_t result_s;
    mul_result_t result_r;

    assign last_iter_s = (state_r == BUSY) && (cnt_r == CNT_LAST);

    // One shift-add step: conditional add, then shift {sum,mq} right by one.
    always_comb begin
        addend_s       = mq_r[0] ? {1'b0, mcand_r} : {(MULTIPLICAND_LENGTH+1){1'b0}};
        sum_s          = acc_r + addend_s;
        acc_next_s     = {1'b0, sum_s[MULTIPLICAND_LENGTH:1]};
        mq_next_s      = {sum_s[0], mq_r[MULTIPLIER_LENGTH-1:1]};
        product_next_s = {acc_next_s[MULTIPLICAND_LENGTH-1:0], mq_next_s};
    end

    mul_norm_sticky #(
        .MANT_W (MULTIPLICAND_LENGTH)
    ) u_norm_sticky (
        .product  (product_next_s),
        .norm     (norm_next_s),
        .mantissa (mant_next_s),
        .sticky   (sticky_next_s)
    );

    assign result_s = '{product:  product_next_s,
                        norm:     norm_next_s,
                        mantissa: mant_next_s,
                        sticky:   sticky_next_s};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM handshake outputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            BUSY:    in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Operand capture, iteration and result latch; the result only moves on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {(MULTIPLICAND_LENGTH+1){1'b0}};
            mcand_r  <= {MULTIPLICAND_LENGTH{1'b0}};
            mq_r     <= {MULTIPLIER_LENGTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        acc_r   <= {(MULTIPLICAND_LENGTH+1){1'b0}};
                        mcand_r <= a;
                        mq_r    <= b;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                BUSY: begin
                    acc_r <= acc_next_s;
                    mq_r  <= mq_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_iter_s) begin
                        result_r <= result_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign product  = result_r.product;
    assign norm     = result_r.norm;
    assign mantissa = result_r.mantissa;
    assign sticky   = result_r.sticky;

endmodule

// File: tb/tb_nrd_mantissa_multiplier.sv
// Directed bench for the shift-add significand multiplier: table of hand-computed
// products plus backpressure, mid-operation reset and issue-interval sequences.
module tb_nrd_mantissa_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a;
    logic [23:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] product;
    logic        norm;
    logic [23:0] mantissa;
    logic        sticky;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] p;
        logic        n;
        logic [23:0] m;
        logic        s;
    } vec_t;

    vec_t vecs[8];

    nrd_mantissa_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .norm      (norm),
        .mantissa  (mantissa),
        .sticky    (sticky)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one op, wait for the result, check latency and fields; optionally consume it.
    task automatic run_op(input logic [23:0] av, input logic [23:0] bv,
                          input logic [47:0] ep, input logic en, input logic [23:0] em,
                          input logic es, input bit consume, input string tag,
                          output int acc_cyc);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a = 24'($urandom);
        b = 24'($urandom);
        lat = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd24);
        check({tag, "_product"}, 64'(product), 64'(ep));
        check({tag, "_norm"}, 64'(norm), 64'(en));
        check({tag, "_mantissa"}, 64'(mantissa), 64'(em));
        check({tag, "_sticky"}, 64'(sticky), 64'(es));
        if (consume) begin
            tick();
        end
    endtask

    function automatic vec_t model(input logic [23:0] av, input logic [23:0] bv);
        vec_t v;
        logic [47:0] p;
        p   = {24'd0, av} * {24'd0, bv};
        v.a = av;
        v.b = bv;
        v.p = p;
        v.n = p[47];
        if (p[47]) begin
            v.m = 24'(p >> 24);
            v.s = (p & 48'h0000_00FF_FFFF) != 48'd0;
        end else begin
            v.m = 24'(p >> 23);
            v.s = (p & 48'h0000_007F_FFFF) != 48'd0;
        end
        return v;
    endfunction

    initial begin
        int prev_acc;
        int this_acc;
        logic [47:0] held;
        vec_t rv;

        vecs[0] = '{24'h800000, 24'h800000, 48'h400000000000, 1'b0, 24'h800000, 1'b0};
        vecs[1] = '{24'hC00000, 24'hC00000, 48'h900000000000, 1'b1, 24'h900000, 1'b0};
        vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1, 24'hFFFFFE, 1'b1};
        vecs[3] = '{24'h000000, 24'hFFFFFF, 48'h000000000000, 1'b0, 24'h000000, 1'b0};
        vecs[4] = '{24'h000001, 24'hFFFFFF, 48'h000000FFFFFF, 1'b0, 24'h000001, 1'b1};
        vecs[5] = '{24'hFFFFFF, 24'h800000, 48'h7FFFFF800000, 1'b0, 24'hFFFFFF, 1'b0};
        vecs[6] = '{24'h800000, 24'hFFFFFF, 48'h7FFFFF800000, 1'b0, 24'hFFFFFF, 1'b0};
        vecs[7] = '{24'hFFFFFF, 24'h000000, 48'h000000000000, 1'b0, 24'h000000, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 24'd0;
        b         = 24'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        check("reset_mantissa", 64'(mantissa), 64'd0);
        check("reset_flags", 64'({norm, sticky}), 64'd0);

        // Back-to-back table with out_ready held high: interval must be 26 cycles.
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].n, vecs[i].m, vecs[i].s,
                   1'b1, $sformatf("vec%0d", i), this_acc);
            if (i > 0) begin
                check($sformatf("vec%0d_interval", i), 64'(this_acc - prev_acc), 64'd26);
            end
            prev_acc = this_acc;
        end

        for (int i = 0; i < 4; i++) begin
            rv = model(24'($urandom), 24'($urandom));
            run_op(rv.a, rv.b, rv.p, rv.n, rv.m, rv.s, 1'b1, $sformatf("rnd%0d", i), this_acc);
            check($sformatf("rnd%0d_interval", i), 64'(this_acc - prev_acc), 64'd26);
            prev_acc = this_acc;
        end

        // Backpressure: result must hold and new operands be ignored.
        out_ready = 1'b0;
        run_op(24'hC00000, 24'hC00000, 48'h900000000000, 1'b1, 24'h900000, 1'b0,
               1'b0, "bp", this_acc);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 24'h123456 + 24'(i);
            b = 24'h654321;
            tick();
            check($sformatf("bp_hold%0d_product", i), 64'(product), 64'h900000000000);
            check($sformatf("bp_hold%0d_valid_ready", i), 64'({out_valid, in_ready}), 64'b10);
        end
        check("bp_hold_mantissa", 64'(mantissa), 64'h900000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", 64'({out_valid, in_ready}), 64'b01);
        check("bp_release_held", 64'(product), 64'h900000000000);
        run_op(24'h800001, 24'h800000, 48'h400000800000, 1'b0, 24'h800001, 1'b0,
               1'b1, "bp_next", this_acc);

        // Reset in the middle of an operation discards it.
        in_valid = 1'b1;
        a = 24'hFFFFFF;
        b = 24'hFFFFFF;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("mid_busy_ready", 64'({out_valid, in_ready}), 64'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", 64'({out_valid, in_ready}), 64'b01);
        check("mid_rst_product", 64'(product), 64'd0);
        check("mid_rst_fields", 64'({norm, mantissa, sticky}), 64'd0);
        held = product;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) break;
        end
        check("mid_rst_no_stale_valid", 64'(out_valid), 64'd0);
        check("mid_rst_no_stale_product", 64'(product), 64'(held));
        run_op(24'h800000, 24'hA00000, 48'h500000000000, 1'b0, 24'hA00000, 1'b0,
               1'b1, "post_rst", this_acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nrd_mantissa_multiplier.md
Name: nrd_mantissa_multiplier

Overview:
- Sequential radix-2 shift-add multiplier for 24-bit significands, including the hidden bit.
- It is the multiply-side counterpart of the FPU's array divider: it produces the full double-width product together with the normalisation flag and sticky bit that the FP multiply path needs before rounding.
- It has valid/ready handshakes on both sides and processes one operation at a time.
- Sign and exponent handling live upstream and are not part of this block.

Parameters:
- MULTIPLICAND_LENGTH, 24, width of operand a (significand including hidden bit).
- MULTIPLIER_LENGTH, 24, width of operand b; also the number of iteration cycles.
- PRODUCT_LENGTH, MULTIPLICAND_LENGTH+MULTIPLIER_LENGTH (48), derived; must not be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  block can accept operands.
- a  input  MULTIPLICAND_LENGTH  multiplicand significand.
- b  input  MULTIPLIER_LENGTH  multiplier significand.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- product  output  PRODUCT_LENGTH  full unsigned product a*b.
- norm  output  1  product[PRODUCT_LENGTH-1]; 1 means the significand is in [2,4) and needs a 1-bit right shift.
- mantissa  output  MULTIPLICAND_LENGTH  retained significand: product[47:24] if norm, else product[46:23].
- sticky  output  1  OR of all product bits below the retained mantissa.

Behaviour:
- Interface timing: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - State goes to IDLE and the counter to 0.
  - in_ready=1, out_valid=0.
  - product, mantissa, norm and sticky all =0.
  - Reset overrides everything, including an operation in progress; a partial result is discarded and never presented.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: acc<=0 (MULTIPLICAND_LENGTH+1 bits), mcand<=a, mq<=b, cnt<=0, go to BUSY.
- BUSY:
  - in_ready=0 and out_valid=0.
  - Each edge: sum = acc + (mq[0] ? mcand : 0), computed at MULTIPLICAND_LENGTH+1 bits so the carry is kept.
  - Then {acc,mq} <= {sum,mq} >> 1, and cnt<=cnt+1.
  - When cnt==MULTIPLIER_LENGTH-1 at the edge, go to DONE.
- Latency:
  - out_valid rises exactly MULTIPLIER_LENGTH (24) edges after the accepting edge.
  - The latency is fixed and independent of operand values; there is no early termination.
- DONE:
  - out_valid=1.
  - product={acc[MULTIPLICAND_LENGTH-1:0],mq}; norm, mantissa and sticky are derived from product.
  - All outputs stay stable while out_valid && !out_ready.
  - On out_ready at an edge, go to IDLE.
- in_ready is 1 only in IDLE. A new operation cannot be accepted in the same cycle a result is consumed, so the minimum issue interval is MULTIPLIER_LENGTH+2 cycles.
- Input handling:
  - in_valid while not ready is ignored; no operand capture occurs.
  - a and b are sampled only at the accepting edge; later changes to them have no effect.
- Zero operands: a=0 or b=0 gives product=0, norm=0, mantissa=0, sticky=0, with the same latency.
- Width rule: acc must be MULTIPLICAND_LENGTH+1 bits wide; dropping the carry corrupts the high product bits for a,b ≥ 2^23.
- product, mantissa, norm and sticky outside DONE: hold their last DONE values (0 after reset). They are qualified only by out_valid.

Decomposition:
- Shared FPU package holds:
  - MANT_LENGTH=24 and PROD_LENGTH=48 constants;
  - the state enum {IDLE,BUSY,DONE};
  - a result struct {product,norm,mantissa,sticky}, shared with the rounding stage.
- One natural sub-module: mul_norm_sticky, combinational, mapping product to {norm,mantissa,sticky}. It is reusable by the divider's rounding path.
- The FSM, counter and datapath stay in the top module.

Test Plan:
- a=0x800000, b=0x800000 -> out_valid 24 edges after accept; product=0x400000000000, norm=0, mantissa=0x800000, sticky=0.
- a=0xC00000, b=0xC00000 -> product=0x900000000000, norm=1, mantissa=0x900000, sticky=0.
- a=0xFFFFFF, b=0xFFFFFF -> product=0xFFFFFE000001, norm=1, mantissa=0xFFFFFE, sticky=1. Exercises the carry bit of acc.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE, and a new op (a=0x800001, b=0x800000 -> product=0x400000800000, mantissa=0x800001, sticky=0) is accepted the next cycle.
- Reset asserted at BUSY cycle 12 -> next cycle in_ready=1, out_valid=0, outputs 0. A following op a=0x800000, b=0xA00000 completes with product=0x500000000000, norm=0, mantissa=0xA00000.
- a=0 with b=0xFFFFFF, then back-to-back random pairs with out_ready=1 -> product matches a*b, no spurious out_valid, and the issue interval is exactly 26 cycles.
